// File: rtl/ahb_vga_wbuf.sv
// AHB-Lite write-post buffer for a VGA console/image pair, plus console/image pixel mux.
// Optional FIFO flush through the control register is enabled by defining VGA_WBUF_FLUSH_EN.
module ahb_vga_wbuf #(
    parameter int FIFO_DEPTH  = 8,
    parameter int PIX_W       = 8,
    parameter int SPLIT_X_RST = 240
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    input  logic             scroll,
    input  logic [9:0]       pixel_x,
    input  logic [PIX_W-1:0] console_rgb,
    input  logic [PIX_W-1:0] image_rgb,
    output logic             console_we,
    output logic [PIX_W-1:0] console_wdata,
    output logic             image_we,
    output logic [13:0]      image_addr,
    output logic [PIX_W-1:0] image_wdata,
    output logic [PIX_W-1:0] rgb_out
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 1 + 14 + PIX_W;

    logic [23:0]      addr_reg;
    logic             write_reg;
    logic             valid_reg;
    logic [9:0]       split_x_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];

    logic sel_console, sel_status, sel_split, sel_ctrl, sel_image;
    logic wr_phase, rd_phase, push_req, push, pop, flush, full, empty;
    logic [ENT_W-1:0] push_entry;
    logic [ENT_W-1:0] pop_entry;
    logic             pop_kind;
    logic             unused_bits;

    assign unused_bits = ^{HADDR[31:24], HTRANS[0], HWDATA};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_reg  <= '0;
            write_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else if (HREADY) begin
            addr_reg  <= HADDR[23:0];
            write_reg <= HWRITE;
            valid_reg <= HSEL & HTRANS[1];
        end
    end

    assign sel_console = (addr_reg == 24'h000000);
    assign sel_status  = (addr_reg == 24'h000004);
    assign sel_split   = (addr_reg == 24'h000008);
    assign sel_ctrl    = (addr_reg == 24'h00000C);
    assign sel_image   = (addr_reg >= 24'h000010);

    assign wr_phase = valid_reg & write_reg;
    assign rd_phase = valid_reg & ~write_reg;
    assign push_req = wr_phase & (sel_console | sel_image);
    assign full     = (level_reg == LVL_W'(FIFO_DEPTH));
    assign empty    = (level_reg == '0);

`ifdef VGA_WBUF_FLUSH_EN
    assign flush = wr_phase & sel_ctrl & HWDATA[0];
`else
    assign flush = 1'b0;
`endif

    // A pushing write that meets a full FIFO holds the bus until a slot frees up.
    assign HREADYOUT  = ~(push_req & full);
    assign push       = push_req & ~full & ~flush;
    assign pop        = ~empty & ~scroll;
    assign push_entry = {sel_image, (sel_image ? addr_reg[15:2] : 14'd0), HWDATA[PIX_W-1:0]};
    assign pop_entry  = mem[rd_ptr_reg];
    assign pop_kind   = pop_entry[ENT_W-1];

    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            // Collapse the write pointer onto the post-pop read pointer.
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
            wr_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(push);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
            level_reg  <= level_reg + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            console_we    <= 1'b0;
            console_wdata <= '0;
            image_we      <= 1'b0;
            image_addr    <= '0;
            image_wdata   <= '0;
        end else begin
            console_we    <= pop & ~pop_kind;
            console_wdata <= (pop & ~pop_kind) ? pop_entry[PIX_W-1:0] : '0;
            image_we      <= pop & pop_kind;
            image_addr    <= (pop & pop_kind) ? pop_entry[ENT_W-2 -: 14] : '0;
            image_wdata   <= (pop & pop_kind) ? pop_entry[PIX_W-1:0] : '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            split_x_reg <= 10'(SPLIT_X_RST);
            rgb_out     <= '0;
        end else begin
            if (wr_phase & sel_split) begin
                split_x_reg <= HWDATA[9:0];
            end
            rgb_out <= (pixel_x < split_x_reg) ? console_rgb : image_rgb;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (rd_phase && sel_status) begin
            HRDATA[0]    = empty;
            HRDATA[1]    = full;
            HRDATA[2]    = scroll;
            HRDATA[15:8] = {{(8 - LVL_W){1'b0}}, level_reg};
        end else if (rd_phase && sel_split) begin
            HRDATA[9:0] = split_x_reg;
        end
    end
endmodule

// File: tb/tb_ahb_vga_wbuf.sv
// Randomized scoreboard bench for ahb_vga_wbuf: bus tasks queue expected drain entries, a monitor checks pulses.
module tb_ahb_vga_wbuf;
    localparam int DEPTH = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        hreadyout;
    logic [31:0] HRDATA;
    logic        scroll = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [7:0]  console_rgb = '0;
    logic [7:0]  image_rgb = '0;
    logic        console_we, image_we;
    logic [7:0]  console_wdata, image_wdata, rgb_out;
    logic [13:0] image_addr;

    ahb_vga_wbuf #(.FIFO_DEPTH(DEPTH), .PIX_W(8), .SPLIT_X_RST(240)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hreadyout), .HREADYOUT(hreadyout),
        .HRDATA(HRDATA), .scroll(scroll), .pixel_x(pixel_x), .console_rgb(console_rgb),
        .image_rgb(image_rgb), .console_we(console_we), .console_wdata(console_wdata),
        .image_we(image_we), .image_addr(image_addr), .image_wdata(image_wdata), .rgb_out(rgb_out)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        img;
        logic [13:0] addr;
        logic [7:0]  data;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [9:0] split_model = 10'd240;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every drain pulse must match the oldest outstanding write.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (console_we || image_we) begin
                ent_t e;
                checks++;
                if (console_we && image_we) begin
                    errors++;
                    $display("FAIL drain_both: console_we and image_we high together");
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL drain_unexpected: pulse cwe=%b iwe=%b addr=%h data=%h%h, none expected",
                             console_we, image_we, image_addr, console_wdata, image_wdata);
                end else begin
                    e = sb.pop_front();
                    if (image_we !== e.img ||
                        (e.img && (image_addr !== e.addr || image_wdata !== e.data || console_wdata !== 8'h0)) ||
                        (!e.img && (console_wdata !== e.data || image_addr !== 14'h0 || image_wdata !== 8'h0))) begin
                        errors++;
                        $display("FAIL drain_entry: got iwe=%b addr=%h cdata=%h idata=%h expected img=%b addr=%h data=%h",
                                 image_we, image_addr, console_wdata, image_wdata, e.img, e.addr, e.data);
                    end
                end
            end else begin
                checks++;
                if (console_wdata !== 8'h0 || image_wdata !== 8'h0 || image_addr !== 14'h0) begin
                    errors++;
                    $display("FAIL idle_outputs: cdata=%h idata=%h addr=%h expected all 0",
                             console_wdata, image_wdata, image_addr);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge HCLK);
        while (!hreadyout && n < 300) begin
            n++;
            @(negedge HCLK);
        end
        if (!hreadyout) begin
            checks++;
            errors++;
            $display("FAIL hready_timeout: HREADYOUT=0 after %0d cycles, required 1", n);
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w;
        wait_ready();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    // Reference map: offset 0 console, >=0x10 image with word address, 8 split_x.
    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        logic [23:0] off;
        ent_t e;
        off = a[23:0];
        if (off == 24'h0) begin
            e.img = 1'b0; e.addr = 14'h0; e.data = d[7:0]; sb.push_back(e);
        end else if (off >= 24'h10) begin
            e.img = 1'b1; e.addr = 14'((off >> 2) & 24'h3FFF); e.data = d[7:0]; sb.push_back(e);
        end else if (off == 24'h8) begin
            split_model = d[9:0];
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr_phase(a, 1'b1);
        HWDATA = d;
        expect_write(a, d);
        wait_ready();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr_phase(a, 1'b0);
        @(negedge HCLK);
        d = HRDATA;
        check("read_zero_wait", 32'(hreadyout), 32'h1);
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_status(input string name, input int lvl);
        logic [31:0] s;
        bus_read(32'h4, s);
        check(name, s, {16'h0, 8'(lvl), 5'h0, scroll, (lvl == DEPTH), (lvl == 0)});
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge HCLK);
            n++;
        end
        repeat (2) @(posedge HCLK);
        #1;
        check("drain_complete", 32'(sb.size()), 32'h0);
    endtask

    task automatic check_rgb(input logic [9:0] px);
        logic [7:0] c, i;
        pixel_x = px;
        c = 8'($urandom);
        i = 8'($urandom);
        console_rgb = c;
        image_rgb = i;
        @(posedge HCLK);
        #1;
        check("rgb_out", 32'(rgb_out), 32'((px < split_model) ? c : i));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, d, a;
        int sel;

        // Reset state
        #1;
        check("rst_hreadyout", 32'(hreadyout), 32'h1);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_we", {30'h0, console_we, image_we}, 32'h0);
        check("rst_rgb", 32'(rgb_out), 32'h0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        check_status("rst_status", 0);
        bus_read(32'h8, r);
        check("rst_split_x", r, 32'd240);

        // Single console write drains in one pulse
        bus_write(32'h0, 32'h41);
        wait_drain();
        check_status("console_level0", 0);

        // Stall on the write after the FIFO fills under scroll
        scroll = 1'b1;
        for (int i = 0; i < DEPTH; i++) bus_write(32'h100 + 32'(4 * i), $urandom);
        check_status("full_status", DEPTH);
        addr_phase(32'h100 + 32'(4 * DEPTH), 1'b1);
        d = $urandom;
        HWDATA = d;
        expect_write(32'h100 + 32'(4 * DEPTH), d);
        repeat (3) begin
            @(negedge HCLK);
            check("stall_hreadyout", 32'(hreadyout), 32'h0);
        end
        @(posedge HCLK);
        #1;
        scroll = 1'b0;
        wait_ready();
        wait_drain();
        check_status("after_stall_level0", 0);

        // Console/image pixel split
        bus_write(32'h8, 32'd100);
        bus_read(32'h8, r);
        check("split_readback", r, 32'd100);
        check_rgb(10'd99);
        check_rgb(10'd100);
        for (int i = 0; i < 6; i++) check_rgb(10'($urandom_range(90, 110)));

        // Reset with entries pending
        scroll = 1'b1;
        for (int i = 0; i < 5; i++) bus_write(32'h200 + 32'(4 * i), $urandom);
        check_status("pending5", 5);
        #3;
        HRESETn = 1'b0;
        #1;
        check("midrst_hreadyout", 32'(hreadyout), 32'h1);
        check("midrst_we", {30'h0, console_we, image_we}, 32'h0);
        check("midrst_hrdata", HRDATA, 32'h0);
        sb.delete();
        split_model = 10'd240;
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        scroll = 1'b0;
        repeat (10) @(posedge HCLK);
        #1;
        check_status("postrst_level0", 0);
        bus_read(32'h8, r);
        check("postrst_split", r, 32'd240);

        // Control write: flush when enabled, ignored otherwise
        scroll = 1'b1;
        for (int i = 0; i < 4; i++) bus_write(32'h0, $urandom);
        bus_write(32'hC, 32'h1);
`ifdef VGA_WBUF_FLUSH_EN
        sb.delete();
        check_status("flush_level", 0);
`else
        check_status("noflush_level", 4);
`endif
        scroll = 1'b0;
        wait_drain();

        // Push and pop in the same cycle at level 3
        scroll = 1'b1;
        for (int i = 0; i < 3; i++) bus_write(32'h300 + 32'(4 * i), $urandom);
        addr_phase(32'h30C, 1'b1);
        d = $urandom;
        HWDATA = d;
        expect_write(32'h30C, d);
        scroll = 1'b0;
        wait_ready();
        scroll = 1'b1;
        check_status("pushpop_level3", 3);
        scroll = 1'b0;
        wait_drain();

        // Randomized mix of transfers
        for (int t = 0; t < 60; t++) begin
            scroll = (sb.size() < DEPTH - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            sel = $urandom_range(0, 6);
            d = $urandom;
            case (sel)
                0: bus_write(32'h0, d);
                1, 2: begin
                    a = {8'($urandom), 24'($urandom_range(4, 24'h3FFFFF)) << 2};
                    bus_write(a, d);
                end
                3: bus_write(32'h8, 32'($urandom_range(0, 639)));
                4: begin
                    bus_read(32'h8, r);
                    check("rand_split", r, 32'(split_model));
                end
                5: begin
                    a = {8'h0, 24'($urandom_range(4, 24'h3FFFFF)) << 2};
                    bus_read(a, r);
                    check("rand_image_read", r, 32'h0);
                end
                default: begin
                    bus_write(32'h4, d);
                    bus_read(32'h4, r);
                    check("rand_status_hi", {r[31:16], 13'h0, r[2:0] & 3'b100}, {29'h0, scroll, 2'b00});
                end
            endcase
            check_rgb(10'($urandom_range(0, 639)));
        end
        scroll = 1'b0;
        wait_drain();
        check_status("final_level0", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb_vga_wbuf.md
AHB_VGA_WBUF -- requirements
Module: ahb_vga_wbuf

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning write-post FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter PIX_W, default 8, meaning console/image data and RGB width.
REQ-003 SHALL have parameter SPLIT_X_RST, default 240, meaning reset value of the console/image column boundary.
REQ-004 Ports: HCLK in 1 clock; HRESETn in 1 reset. One clock; reset is asynchronous and active-low.
REQ-005 Ports: HSEL in 1; HADDR in 32; HTRANS in 2; HWRITE in 1; HWDATA in 32; HREADY in 1 -- AHB-Lite slave inputs.
REQ-006 Ports: HREADYOUT out 1; HRDATA out 32 -- AHB-Lite slave outputs.
REQ-007 Ports: scroll in 1, console busy; pixel_x in 10, current column; console_rgb in PIX_W; image_rgb in PIX_W.
REQ-008 Ports: console_we out 1; console_wdata out PIX_W; image_we out 1; image_addr out 14; image_wdata out PIX_W; rgb_out out PIX_W.

Function
REQ-009 Address phase captured (HADDR, HWRITE, HSEL, HTRANS) SHALL be registered only when HREADY=1; a transfer is valid when captured HSEL=1 and HTRANS[1]=1.
REQ-010 Map on captured HADDR[23:0]: 0x000000 console data (W), 0x000004 status (R), 0x000008 split_x (R/W, 10 bits), 0x00000C control (W); any other offset >= 0x000010 is image space, image address = HADDR[15:2].
REQ-011 Valid write to console data or image space SHALL push one entry {kind, addr[13:0], HWDATA[PIX_W-1:0]} in its data phase; console entries carry addr 0.
REQ-012 HREADYOUT SHALL be 0 during the data phase of a pushing write while FIFO is full and 1 otherwise; the push completes on the first cycle the FIFO is not full.
REQ-013 Drain: when FIFO not empty and scroll=0, one entry SHALL pop per cycle and drive console_we or image_we high for exactly that one registered cycle with its data/address; otherwise we outputs 0 and data outputs 0.
REQ-014 scroll=1 SHALL pause draining without dropping entries; entries resume in order once scroll=0.
REQ-015 Push and pop in the same cycle SHALL leave the level unchanged; order is strict FIFO; pointers wrap modulo FIFO_DEPTH.
REQ-016 Status read: HRDATA[0]=empty, [1]=full, [2]=scroll, [15:8]=level; other bits 0. split_x read returns it in [9:0]. Reads of data, control and image space return 0. Reads zero-wait.
REQ-017 split_x write SHALL take effect the cycle after the data phase and SHALL NOT enter the FIFO.
REQ-018 rgb_out SHALL be registered, one cycle latency: console_rgb when pixel_x < split_x, else image_rgb.
REQ-019 Writes to status and non-write transfers SHALL have no side effect; HRESP is not provided (always OKAY at top level).

Reset
REQ-020 HRESETn low SHALL asynchronously empty FIFO (level 0), set console_we, image_we, console_wdata, image_wdata, image_addr, rgb_out, HRDATA to 0, HREADYOUT to 1, split_x to SPLIT_X_RST, clear captured address-phase state.
REQ-021 Reset mid-drain or mid-stall SHALL discard all pending entries; no we pulse after reset release until a new push.

Configuration
REQ-022 Macro VGA_WBUF_FLUSH_EN defined: write with HWDATA[0]=1 to 0x00C SHALL empty the FIFO on the next cycle, discarding entries; a push in the same data phase is also discarded; a pop that cycle still completes.
REQ-023 Macro undefined: 0x00C writes SHALL be ignored and FIFO never flushed except by reset.

Verification
REQ-024 Write 0x41 to 0x000000, scroll=0 -> console_we pulse 1 cycle, console_wdata=0x41, status level returns to 0.
REQ-025 scroll=1, 9 writes image 0x000100.. (FIFO_DEPTH=8) -> 9th write HREADYOUT=0 until scroll=0; then 9 image_we pulses, image_addr 0x40..0x48, data in order.
REQ-026 Write split_x=100, pixel_x=99 then 100 -> rgb_out = console_rgb then image_rgb, each one cycle later.
REQ-027 HRESETn low with 5 entries pending -> level 0, HREADYOUT=1, split_x=240, no we pulses after release.
REQ-028 VGA_WBUF_FLUSH_EN, scroll=1, 4 entries, write 1 to 0x00C -> status reads empty=1, level 0; without macro level stays 4.
REQ-029 Simultaneous push and pop at level 3 -> level remains 3, output order preserved.
